// File: rtl/mandelbrot_pixel_scheduler_pkg.sv
// Shared constants, defaults and FSM state type for the Mandelbrot frame scheduler.
package mandelbrot_pkg;
  localparam int FRAC_BITS   = 23;
  localparam int ONE         = 2**FRAC_BITS;
  localparam int COORD_W_DEF = 27;
  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  // Counter width that stays legal for degenerate 1-entry ranges.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/mandelbrot_pixel_scheduler_if.sv
// Job, result and framebuffer-write buses between the scheduler and its cores/memory.
interface mandelbrot_pixel_scheduler_if
  import mandelbrot_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [N_CORES-1:0]              job_valid;
  logic [N_CORES-1:0]              job_ready;
  logic signed [COORD_W-1:0]       job_re;
  logic signed [COORD_W-1:0]       job_im;
  logic [ADDR_W-1:0]               job_addr;
  logic [N_CORES-1:0]              res_valid;
  logic [N_CORES-1:0]              res_ready;
  logic [N_CORES-1:0][DATA_W-1:0]  res_data;
  logic [N_CORES-1:0][ADDR_W-1:0]  res_addr;
  logic [DATA_W-1:0]               mem_write_data;
  logic [ADDR_W-1:0]               mem_write_address;
  logic                            mem_we;

  modport master (
    output job_valid, job_re, job_im, job_addr, res_ready,
           mem_write_data, mem_write_address, mem_we,
    input  job_ready, res_valid, res_data, res_addr
  );
  modport slave (
    input  job_valid, job_re, job_im, job_addr, res_ready,
           mem_write_data, mem_write_address, mem_we,
    output job_ready, res_valid, res_data, res_addr
  );
endinterface

// File: rtl/mandelbrot_pixel_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter: first requester at/after the pointer wins; pointer moves past it.
module rr_arbiter
  import mandelbrot_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  int            idx;

  // Scan from the farthest offset back to the pointer so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    win   = ptr;
    idx   = 0;
    for (int i = N-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (advance && |req)
      ptr <= (win == PW'(N-1)) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Frame controller: raster-walks pixels onto free iterator cores and funnels results to the framebuffer.
module mandelbrot_pixel_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int N_CORES  = 4,
  parameter int X_PIXELS = 640,
  parameter int Y_PIXELS = 480,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic signed [COORD_W-1:0] x_start,
  input  logic signed [COORD_W-1:0] y_start,
  input  logic signed [COORD_W-1:0] pixel_increment,
  output logic                      start,
  output logic                      done,
  output logic                      busy,
  mandelbrot_pixel_scheduler_if.master bus
);
  localparam int TOTAL = X_PIXELS * Y_PIXELS;
  localparam int COL_W = clog2_min1(X_PIXELS);
  localparam int ROW_W = clog2_min1(Y_PIXELS);
  localparam int CNT_W = $clog2(TOTAL + 1);

  state_t                    state;
  logic signed [COORD_W-1:0] x0, inc, cur_re, cur_im;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic [ADDR_W-1:0]         addr;
  logic [CNT_W-1:0]          written;
  logic [N_CORES-1:0]        disp_req, disp_gnt, res_req, res_gnt;
  logic [DATA_W-1:0]         gnt_data;
  logic [ADDR_W-1:0]         gnt_addr;
  logic                      issue, last_px, col_end;

  assign disp_req = (state == DISPATCH) ? bus.job_ready : '0;
  assign res_req  = (state == DISPATCH || state == DRAIN) ? bus.res_valid : '0;
  assign issue    = |disp_req;
  assign col_end  = (col == COL_W'(X_PIXELS-1));
  assign last_px  = col_end && (row == ROW_W'(Y_PIXELS-1));

  rr_arbiter #(.N(N_CORES)) u_disp_arb (
    .clk(clk), .reset(reset), .req(disp_req), .advance(issue), .grant(disp_gnt)
  );
  rr_arbiter #(.N(N_CORES)) u_res_arb (
    .clk(clk), .reset(reset), .req(res_req), .advance(|res_req), .grant(res_gnt)
  );

  assign bus.job_valid = disp_gnt;
  assign bus.res_ready = res_gnt;
  assign bus.job_re    = cur_re;
  assign bus.job_im    = cur_im;
  assign bus.job_addr  = addr;

  always_comb begin
    gnt_data = '0;
    gnt_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (res_gnt[i]) begin
        gnt_data = gnt_data | bus.res_data[i];
        gnt_addr = gnt_addr | bus.res_addr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      start                 <= 1'b0;
      done                  <= 1'b0;
      busy                  <= 1'b0;
      x0                    <= '0;
      inc                   <= '0;
      cur_re                <= '0;
      cur_im                <= '0;
      col                   <= '0;
      row                   <= '0;
      addr                  <= '0;
      written               <= '0;
      bus.mem_we            <= 1'b0;
      bus.mem_write_data    <= '0;
      bus.mem_write_address <= '0;
    end else begin
      start      <= 1'b0;
      bus.mem_we <= |res_gnt;
      if (|res_gnt) begin
        bus.mem_write_data    <= gnt_data;
        bus.mem_write_address <= gnt_addr;
        written               <= written + 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state   <= DISPATCH;
            start   <= 1'b1;
            done    <= 1'b0;
            busy    <= 1'b1;
            x0      <= x_start;
            inc     <= pixel_increment;
            cur_re  <= x_start;
            cur_im  <= y_start;
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            written <= '0;
          end
        end
        DISPATCH: begin
          if (issue) begin
            if (last_px) begin
              state <= DRAIN;
            end else begin
              addr <= addr + 1'b1;
              // Rows step downward in the complex plane, so c_im shrinks per row.
              if (col_end) begin
                col    <= '0;
                row    <= row + 1'b1;
                cur_re <= x0;
                cur_im <= cur_im - inc;
              end else begin
                col    <= col + 1'b1;
                cur_re <= cur_re + inc;
              end
            end
          end
        end
        DRAIN: begin
          if (written == CNT_W'(TOTAL)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Scoreboard bench for the frame scheduler: 4x3 frame, two behavioural iterator cores.
module tb_mandelbrot_pixel_scheduler;
  import mandelbrot_pkg::*;
  localparam int N = 2, X = 4, Y = 3, CW = 27, AW = 19, DW = 8, NPIX = X * Y;

  logic clk = 1'b0, reset = 1'b1, go = 1'b0;
  logic signed [CW-1:0] x_start = '0, y_start = '0, pixel_increment = '0;
  logic start, done, busy;

  mandelbrot_pixel_scheduler_if #(.N_CORES(N), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mandelbrot_pixel_scheduler #(.N_CORES(N), .X_PIXELS(X), .Y_PIXELS(Y),
                               .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .go(go), .x_start(x_start), .y_start(y_start),
    .pixel_increment(pixel_increment), .start(start), .done(done), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int a; longint re; longint im; } job_t;
  job_t exp_jobs[$];

  int n_chk = 0, n_fail = 0;
  int lat[2];
  bit stall = 0, alt_check = 0;
  int mon_jobs = 0, mon_wr = 0, contention = 0, cyc = 0, last_we = -10;
  longint re5 = 0, im5 = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dfun(input int a);
    return (a * 5 + 1) & 255;
  endfunction

  // Behavioural iterator cores: accept a job, hold it `lat` cycles, present the result until granted.
  initial begin
    bit   cbusy[2];
    int   ccnt[2], caddr[2], ja;
    logic [1:0] acc, gnt;
    bit   r;
    cbusy = '{0, 0}; ccnt = '{0, 0}; caddr = '{0, 0};
    bus.job_ready = '0; bus.res_valid = '0; bus.res_data = '0; bus.res_addr = '0;
    forever begin
      @(posedge clk);
      acc = bus.job_valid & bus.job_ready; gnt = bus.res_ready;
      ja = int'(bus.job_addr); r = reset;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (r) begin cbusy[i] = 0; ccnt[i] = 0; end
        else if (gnt[i] === 1'b1) cbusy[i] = 0;
        else if (acc[i] === 1'b1) begin cbusy[i] = 1; ccnt[i] = lat[i]; caddr[i] = ja; end
        else if (cbusy[i] && ccnt[i] > 0) ccnt[i]--;
        bus.job_ready[i] = !cbusy[i] && !stall;
        bus.res_valid[i] = cbusy[i] && ccnt[i] == 0;
        bus.res_data[i]  = DW'(dfun(caddr[i]));
        bus.res_addr[i]  = AW'(caddr[i]);
      end
    end
  end

  // Monitor: pops expected jobs, checks writes one cycle after each grant, arbitration fairness, done.
  initial begin
    bit pend = 0, prev_both = 0, prev_done = 0;
    int pend_a = 0, pend_d = 0, g, cnt;
    logic [1:0] prev_gnt = '0;
    bit wrote[NPIX];
    job_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_jobs.delete(); pend = 0; prev_both = 0; prev_done = 0; mon_wr = 0; mon_jobs = 0;
        continue;
      end
      if (start) begin
        mon_wr = 0; mon_jobs = 0;
        for (int i = 0; i < NPIX; i++) wrote[i] = 0;
      end
      if (!busy) chk("no_job_when_idle", bus.job_valid, 0);
      if (bus.job_valid != 0) begin
        chk("job_onehot", $onehot(bus.job_valid), 1);
        chk("job_to_ready_core", bus.job_valid & ~bus.job_ready, 0);
        if (alt_check) chk("job_alternate", bus.job_valid, bus.job_addr[0] ? 2 : 1);
        if (exp_jobs.size() == 0) chk("job_unexpected", bus.job_addr, -1);
        else begin
          e = exp_jobs.pop_front();
          chk("job_addr", bus.job_addr, e.a);
          chk("job_re", bus.job_re, e.re);
          chk("job_im", bus.job_im, e.im);
        end
        if (bus.job_addr == 5) begin re5 = bus.job_re; im5 = bus.job_im; end
        mon_jobs++;
      end
      chk("mem_we_after_grant", bus.mem_we, pend);
      if (pend && bus.mem_we) begin
        chk("mem_addr", bus.mem_write_address, pend_a);
        chk("mem_data", bus.mem_write_data, pend_d);
      end
      if (bus.mem_we) begin
        mon_wr++; last_we = cyc;
        if (bus.mem_write_address < NPIX) begin
          chk("write_once", wrote[bus.mem_write_address], 0);
          wrote[bus.mem_write_address] = 1;
        end else chk("write_addr_range", bus.mem_write_address, NPIX - 1);
      end
      pend = 0;
      if (prev_both) chk("rr_res_order", bus.res_ready, ~prev_gnt & 2'b11);
      if (bus.res_ready != 0) begin
        chk("res_onehot", $onehot(bus.res_ready), 1);
        chk("res_grant_valid", bus.res_ready & ~bus.res_valid, 0);
        g = bus.res_ready[1] ? 1 : 0;
        pend = 1; pend_a = int'(bus.res_addr[g]); pend_d = int'(bus.res_data[g]);
      end
      prev_both = (bus.res_valid == 2'b11);
      if (prev_both) contention++;
      prev_gnt = bus.res_ready;
      if (done && !prev_done) begin
        cnt = 0;
        for (int i = 0; i < NPIX; i++) cnt += wrote[i];
        chk("done_all_written", cnt, NPIX);
        chk("done_write_count", mon_wr, NPIX);
        chk("done_after_last_we", last_we, cyc - 1);
        chk("done_jobs_left", exp_jobs.size(), 0);
        chk("done_busy_low", busy, 0);
      end
      prev_done = done;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_start"}, start, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_job_valid"}, bus.job_valid, 0);
    chk({nm, "_res_ready"}, bus.res_ready, 0);
    chk({nm, "_mem_we"}, bus.mem_we, 0);
    chk({nm, "_mem_data"}, bus.mem_write_data, 0);
    chk({nm, "_mem_addr"}, bus.mem_write_address, 0);
    chk({nm, "_job_re"}, bus.job_re, 0);
    chk({nm, "_job_im"}, bus.job_im, 0);
    chk({nm, "_job_addr"}, bus.job_addr, 0);
  endtask

  task automatic start_frame(input logic signed [CW-1:0] xs, ys, inc);
    job_t j;
    logic signed [CW-1:0] er, ei;
    for (int a = 0; a < NPIX; a++) begin
      er = CW'(xs + inc * (a % X));
      ei = CW'(ys - inc * (a / X));
      j.a = a; j.re = er; j.im = ei;
      exp_jobs.push_back(j);
    end
    @(posedge clk); #2;
    x_start = xs; y_start = ys; pixel_increment = inc; go = 1'b1;
    @(posedge clk); #2 go = 1'b0;
    @(negedge clk);
    chk("start_pulse", start, 1);
    chk("start_busy", busy, 1);
    chk("start_done_clear", done, 0);
    @(negedge clk);
    chk("start_one_cycle", start, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_reached", done, 1);
  endtask

  initial begin
    int sa, c0;
    lat = '{3, 3};
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Raster walk and fair alternation with identical latencies.
    alt_check = 1;
    start_frame(CW'(-2 * ONE), CW'(ONE), CW'(39000));
    wait_done(400);
    alt_check = 0;
    chk("job5_re", re5, -16738216);
    chk("job5_im", im5, 8349608);

    // Staggered latencies make both results land in the same cycle.
    lat = '{4, 3};
    c0 = contention;
    start_frame(CW'(ONE / 2), CW'(-ONE), CW'(-1000));
    wait_done(400);
    chk("contention_seen", contention > c0, 1);
    lat = '{3, 3};

    // Stall all cores mid-frame.
    start_frame(CW'(0), CW'(0), CW'(12345));
    for (int i = 0; i < 200 && mon_jobs < 5; i++) @(negedge clk);
    stall = 1;
    @(posedge clk); #2 sa = int'(bus.job_addr);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_no_job", bus.job_valid, 0);
    end
    chk("stall_addr_frozen", bus.job_addr, sa);
    chk("stall_next_addr", sa, mon_jobs);
    stall = 0;
    wait_done(400);

    // go while busy is ignored.
    start_frame(CW'(-ONE), CW'(ONE / 4), CW'(70000));
    @(posedge clk); #2 x_start = CW'(123456); go = 1'b1;
    @(posedge clk); #2 go = 1'b0;
    @(negedge clk);
    chk("busy_go_no_start", start, 0);
    chk("busy_go_still_busy", busy, 1);
    wait_done(400);

    // Reset mid-frame, then a clean frame.
    lat = '{2, 5};
    start_frame(CW'(ONE), CW'(-ONE), CW'(-50000));
    for (int i = 0; i < 200 && mon_wr < 5; i++) @(negedge clk);
    chk("midreset_writes", mon_wr >= 5, 1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    start_frame(CW'(3 * ONE), CW'(2 * ONE), CW'(-200000));
    wait_done(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
